regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file: one write port, NUM_READ combinational or registered read ports, configurable width and depth.
- Adds features the single-configuration regfile lacks:
  - optional hardwired-zero register 0
  - write-to-read bypass
  - optional registered read outputs
  - a multi-cycle sweep-clear engine with a busy indication.
- Sits in the processor datapath between decode (read addresses) and writeback (write port).

Parameters:
- DATA_WIDTH, 32, bits per register.
- NUM_REGS, 32, number of registers (need not be a power of two; minimum 2).
- ADDR_WIDTH, clog2(NUM_REGS), address width; derived, not overridden.
- NUM_READ, 2, number of read ports (1..8).
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes.
- BYPASS, 1, 1 = a read of the register being written this cycle returns data_writeReg.
- READ_REG, 0, 0 = combinational reads (latency 0); 1 = read data registered (latency 1).

Ports:
- clock  in  1  single clock, rising edge.
- ctrl_reset  in  1  asynchronous, active-low reset.
- ctrl_writeEnable  in  1  write strobe.
- ctrl_writeReg  in  ADDR_WIDTH  write address.
- data_writeReg  in  DATA_WIDTH  write data.
- ctrl_readReg  in  NUM_READ*ADDR_WIDTH  read addresses; port p = bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- data_readReg  out  NUM_READ*DATA_WIDTH  read data; port p = bits [p*DATA_WIDTH +: DATA_WIDTH].
- ctrl_clear  in  1  request a sweep clear of all registers.
- clear_busy  out  1  high while the sweep is in progress.
- write_dropped  out  1  one-cycle pulse: a write was refused because a sweep was in progress.

Behaviour:
- Reset (ctrl_reset=0, async):
  - all storage 0; FSM IDLE; sweep counter 0.
  - clear_busy=0, write_dropped=0.
  - data_readReg=0 when READ_REG=1.
  - Deassertion takes effect at the next rising edge.
- Write:
  - Accepted at the rising edge when ctrl_writeEnable=1, FSM=IDLE and ctrl_writeReg < NUM_REGS.
  - Discarded without flag if the target is register 0 and ZERO_REG=1.
  - Discarded without flag if the address is >= NUM_REGS.
- Read, per port, independent:
  - Value = 0 if the address is >= NUM_REGS, or if the address is 0 and ZERO_REG=1.
  - Otherwise, if BYPASS=1 and a write to the same address is accepted this cycle, value = data_writeReg.
  - Otherwise value = stored content.
  - READ_REG=0: data_readReg = value combinationally.
  - READ_REG=1: data_readReg is updated with value at each rising edge (1-cycle latency). Bypass is evaluated in the address cycle.
- Sweep-clear FSM, states IDLE, CLEAR:
  - IDLE -> CLEAR when ctrl_clear=1 is sampled at an edge; counter set to 0.
  - In CLEAR, each edge zeroes register[counter] and increments counter.
  - When counter==NUM_REGS-1, that register is cleared and FSM -> IDLE.
  - clear_busy = (state==CLEAR), registered. It is high for exactly NUM_REGS cycles, starting the cycle after ctrl_clear is sampled.
  - ctrl_clear while in CLEAR is ignored; the sweep does not restart.
  - A write in the same cycle ctrl_clear is sampled in IDLE is accepted; the later sweep zeroes it.
  - Writes while in CLEAR are not performed. write_dropped pulses high in the cycle following the refused write edge.
  - Reads during CLEAR return current storage: already-swept registers read 0, the rest keep their old values. No bypass during CLEAR.
- Async reset mid-sweep: FSM -> IDLE immediately and all storage is 0.
- Simultaneous accepted write and read of the same address with BYPASS=0: the read returns the old value, and the new value is visible from the next cycle.

Decomposition:
- Shared include regfile_pkg holds:
  - clog2 constant function
  - FSM state encodings (RF_IDLE=1'b0, RF_CLEAR=1'b1)
  - the flattened-port slicing macros.
- One sub-module, regfile_clear_ctrl, contains the FSM, sweep counter, clear_busy and write_dropped logic. It exports the sweep index and a sweep-write strobe to the storage array.

Test Plan:
- Reset then read all ports: default params, reset asserted -> every data_readReg port = 0; clear_busy=0.
- Write/read with bypass: write 0xDEADBEEF to r5 while port0 reads r5 in the same cycle (BYPASS=1, READ_REG=0) -> port0=0xDEADBEEF that cycle. Same with BYPASS=0 -> 0 that cycle, 0xDEADBEEF the next.
- Zero register: write 0x12345678 to r0 with ZERO_REG=1 -> all reads of r0 = 0. Repeat with ZERO_REG=0 -> r0 reads 0x12345678.
- Sweep clear: fill r1..r31 with their index, pulse ctrl_clear, then write r3 during cycle 2 of the sweep:
  - clear_busy high for exactly 32 cycles
  - write_dropped pulses once
  - after the sweep all registers read 0.
- Odd config and registered reads: NUM_REGS=24, NUM_READ=3, READ_REG=1. Write r23=0xA5, read r23 on port2 and r30 on port1 -> port2=0xA5 one cycle after address, port1=0; a write to r30 leaves storage unchanged.
- Reset mid-sweep: assert ctrl_reset at sweep cycle 10 -> clear_busy=0 immediately. After release, a new write to r7=0x55 reads back 0x55.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, constants and helpers for the multi-port register file.
// Flattened-port slicing macros live here so every file slices ports the same way.
`ifndef REGFILE_PKG_SV
`define REGFILE_PKG_SV

`define RF_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rfState_e;

  // Ceiling log2 for n >= 2 (address width of an n-entry array).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/regfile_clear_ctrl.sv
// Sweep-clear controller: walks every register index once after a clear request,
// and flags writes that arrive while the sweep owns the array.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_clear,
  input  logic                  ctrl_writeEnable,
  output logic                  clear_busy,
  output logic                  write_dropped,
  output logic [ADDR_WIDTH-1:0] sweepIdx,
  output logic                  sweepWe
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_REGS - 1);

  rfState_e              state;
  rfState_e              stateNext;
  logic [ADDR_WIDTH-1:0] idxNext;
  logic                  droppedNext;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state         <= RF_IDLE;
      sweepIdx      <= '0;
      write_dropped <= 1'b0;
    end else begin
      state         <= stateNext;
      sweepIdx      <= idxNext;
      write_dropped <= droppedNext;
    end
  end

  always_comb begin
    stateNext   = state;
    idxNext     = sweepIdx;
    droppedNext = 1'b0;
    unique case (state)
      RF_IDLE: begin
        if (ctrl_clear) begin
          stateNext = RF_CLEAR;
          idxNext   = '0;
        end
      end
      RF_CLEAR: begin
        // A second clear request here is deliberately ignored.
        droppedNext = ctrl_writeEnable;
        if (sweepIdx == LastIdx) begin
          stateNext = RF_IDLE;
          idxNext   = '0;
        end else begin
          idxNext = sweepIdx + ADDR_WIDTH'(1);
        end
      end
    endcase
  end

  assign clear_busy = (state == RF_CLEAR);
  assign sweepWe    = (state == RF_CLEAR);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: one write port, NUM_READ read ports, optional
// hardwired zero register, write-to-read bypass, registered reads and sweep clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned READ_REG   = 0,
  localparam int unsigned ADDR_WIDTH = clog2(NUM_REGS)
) (
  input  logic                           clock,
  input  logic                           ctrl_reset,
  input  logic                           ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]          data_writeReg,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
  input  logic                           ctrl_clear,
  output logic                           clear_busy,
  output logic                           write_dropped
);

  localparam int unsigned Span = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic [ADDR_WIDTH-1:0] sweepIdx;
  logic                  sweepWe;
  logic [Span-1:0]       addrValid;
  logic                  isZeroTarget;
  logic                  writeAccept;

  regfile_clear_ctrl #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clearCtrl (
    .clock           (clock),
    .ctrl_reset      (ctrl_reset),
    .ctrl_clear      (ctrl_clear),
    .ctrl_writeEnable(ctrl_writeEnable),
    .clear_busy      (clear_busy),
    .write_dropped   (write_dropped),
    .sweepIdx        (sweepIdx),
    .sweepWe         (sweepWe)
  );

  // Per-address validity table; covers non-power-of-two depths without range compares.
  for (genvar i = 0; i < Span; i++) begin : gValid
    assign addrValid[i] = (i < NUM_REGS);
  end

  assign isZeroTarget = (ZERO_REG != 0) && (ctrl_writeReg == '0);
  assign writeAccept  = ctrl_writeEnable && !clear_busy
                        && addrValid[ctrl_writeReg] && !isZeroTarget;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (sweepWe) begin
      mem[sweepIdx] <= '0;
    end else if (writeAccept) begin
      mem[ctrl_writeReg] <= data_writeReg;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : gRead
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] value;

    assign addr = `RF_SLICE(ctrl_readReg, p, ADDR_WIDTH);

    // writeAccept is already false during a sweep, so bypass never fires then.
    always_comb begin
      value = '0;
      if (!addrValid[addr] || ((ZERO_REG != 0) && (addr == '0))) begin
        value = '0;
      end else if ((BYPASS != 0) && writeAccept && (addr == ctrl_writeReg)) begin
        value = data_writeReg;
      end else begin
        value = mem[addr];
      end
    end

    if (READ_REG != 0) begin : gReg
      logic [DATA_WIDTH-1:0] readQ;
      always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
          readQ <= '0;
        end else begin
          readQ <= value;
        end
      end
      assign `RF_SLICE(data_readReg, p, DATA_WIDTH) = readQ;
    end else begin : gComb
      assign `RF_SLICE(data_readReg, p, DATA_WIDTH) = value;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three configurations driven side by side,
// expected values written out by hand.
module tb_regfile_mp;

  logic clock;
  logic ctrl_reset;

  // Instances A0 (defaults) and A1 (no bypass, no zero reg) share stimulus.
  logic        aWe;
  logic [4:0]  aWr;
  logic [31:0] aData;
  logic [9:0]  aRd;
  logic        aClr;
  logic [63:0] aRdData0, aRdData1;
  logic        aBusy0, aBusy1, aDrop0, aDrop1;

  // Instance B: 24 registers, 3 read ports, registered reads.
  logic        bWe;
  logic [4:0]  bWr;
  logic [31:0] bData;
  logic [14:0] bRd;
  logic        bClr;
  logic [95:0] bRdData;
  logic        bBusy, bDrop;

  int nChecks = 0;
  int nPass   = 0;
  int busyCnt;
  int dropCnt;
  int nonZero;

  regfile_mp u_a0 (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(aWe), .ctrl_writeReg(aWr), .data_writeReg(aData),
    .ctrl_readReg(aRd), .data_readReg(aRdData0),
    .ctrl_clear(aClr), .clear_busy(aBusy0), .write_dropped(aDrop0)
  );

  regfile_mp #(.ZERO_REG(0), .BYPASS(0)) u_a1 (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(aWe), .ctrl_writeReg(aWr), .data_writeReg(aData),
    .ctrl_readReg(aRd), .data_readReg(aRdData1),
    .ctrl_clear(aClr), .clear_busy(aBusy1), .write_dropped(aDrop1)
  );

  regfile_mp #(.NUM_REGS(24), .NUM_READ(3), .READ_REG(1)) u_b (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(bWe), .ctrl_writeReg(bWr), .data_writeReg(bData),
    .ctrl_readReg(bRd), .data_readReg(bRdData),
    .ctrl_clear(bClr), .clear_busy(bBusy), .write_dropped(bDrop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) begin
      nPass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    aWe = 0; aWr = 0; aData = 0; aRd = 0; aClr = 0;
    bWe = 0; bWr = 0; bData = 0; bRd = 0; bClr = 0;
    ctrl_reset = 1'b1;
    #2 ctrl_reset = 1'b0;
    #20;

    // Reset state
    checkVal("rst_a0_p0", 64'(aRdData0[31:0]), 64'h0);
    checkVal("rst_a0_p1", 64'(aRdData0[63:32]), 64'h0);
    checkVal("rst_a1_p0", 64'(aRdData1[31:0]), 64'h0);
    checkVal("rst_b_all", 64'(bRdData[95:64] | bRdData[63:32] | bRdData[31:0]), 64'h0);
    checkVal("rst_busy", 64'({aBusy0, aBusy1, bBusy}), 64'h0);
    checkVal("rst_drop", 64'({aDrop0, aDrop1, bDrop}), 64'h0);
    @(negedge clock);
    ctrl_reset = 1'b1;
    tick();

    // Same-cycle write and read of r5
    aWe = 1; aWr = 5'd5; aData = 32'hDEADBEEF; aRd = {5'd5, 5'd5};
    #1;
    checkVal("bypass_a0", 64'(aRdData0[31:0]), 64'hDEADBEEF);
    checkVal("nobypass_a1", 64'(aRdData1[31:0]), 64'h0);
    tick();
    aWe = 0;
    #1;
    checkVal("after_wr_a0", 64'(aRdData0[63:32]), 64'hDEADBEEF);
    checkVal("after_wr_a1", 64'(aRdData1[31:0]), 64'hDEADBEEF);

    // Register 0 writes
    aWe = 1; aWr = 5'd0; aData = 32'h12345678; aRd = {5'd0, 5'd0};
    #1;
    checkVal("r0_same_a0", 64'(aRdData0[31:0]), 64'h0);
    checkVal("r0_same_a1", 64'(aRdData1[31:0]), 64'h0);
    tick();
    aWe = 0;
    #1;
    checkVal("r0_zero_a0", 64'(aRdData0), 64'h0);
    checkVal("r0_store_a1", 64'(aRdData1[31:0]), 64'h12345678);

    // Fill r1..r31 with their index
    for (int i = 1; i < 32; i++) begin
      aWe = 1; aWr = 5'(i); aData = 32'(i);
      tick();
    end
    aWe = 0; aRd = {5'd17, 5'd31};
    #1;
    checkVal("fill_a0_r31", 64'(aRdData0[31:0]), 64'd31);
    checkVal("fill_a1_r17", 64'(aRdData1[63:32]), 64'd17);

    // Sweep clear with a refused write to r3 in sweep cycle 2
    aClr = 1;
    tick();
    aClr = 0;
    busyCnt = 0;
    dropCnt = 0;
    for (int c = 1; c <= 40; c++) begin
      aWe = (c == 2);
      aWr = 5'd3; aData = 32'hFFFF0003; aRd = {5'd0, 5'd3};
      #1;
      if (c == 2) begin
        checkVal("sweep_rd_r3", 64'(aRdData0[31:0]), 64'd3);
      end
      if (aBusy0) busyCnt++;
      if (aDrop0) dropCnt++;
      tick();
    end
    aWe = 0;
    checkVal("sweep_busy_cycles", 64'(busyCnt), 64'd32);
    checkVal("sweep_drop_pulses", 64'(dropCnt), 64'd1);
    nonZero = 0;
    for (int a = 0; a < 32; a++) begin
      aRd = {5'(a), 5'(a)};
      #1;
      if (aRdData0[31:0] != 32'h0 || aRdData1[31:0] != 32'h0) nonZero++;
      tick();
    end
    checkVal("sweep_all_zero", 64'(nonZero), 64'd0);

    // Odd depth, three ports, registered reads
    bWe = 1; bWr = 5'd23; bData = 32'hA5; bRd = {5'd23, 5'd30, 5'd0};
    #1;
    checkVal("b_lat_before", 64'(bRdData[95:64]), 64'h0);
    tick();
    checkVal("b_p2_r23", 64'(bRdData[95:64]), 64'hA5);
    checkVal("b_p1_r30", 64'(bRdData[63:32]), 64'h0);
    bWr = 5'd30; bData = 32'hFF; bRd = {5'd23, 5'd30, 5'd23};
    tick();
    bWe = 0;
    checkVal("b_r30_rd", 64'(bRdData[63:32]), 64'h0);
    checkVal("b_r23_keep", 64'(bRdData[95:64]), 64'hA5);
    checkVal("b_p0_r23", 64'(bRdData[31:0]), 64'hA5);
    checkVal("b_no_drop", 64'(bDrop), 64'h0);

    // Reset in the middle of a sweep
    aWe = 1; aWr = 5'd20; aData = 32'h77;
    tick();
    aWe = 0; aClr = 1;
    tick();
    aClr = 0;
    for (int c = 1; c < 10; c++) tick();
    aRd = {5'd0, 5'd20};
    #1;
    checkVal("mid_r20_live", 64'(aRdData0[31:0]), 64'h77);
    checkVal("mid_busy", 64'(aBusy0), 64'h1);
    ctrl_reset = 1'b0;
    #1;
    checkVal("mid_rst_busy", 64'(aBusy0), 64'h0);
    checkVal("mid_rst_r20", 64'(aRdData0[31:0]), 64'h0);
    checkVal("mid_rst_b", 64'(bRdData[95:64]), 64'h0);
    @(negedge clock);
    ctrl_reset = 1'b1;
    tick();
    aWe = 1; aWr = 5'd7; aData = 32'h55;
    tick();
    aWe = 0; aRd = {5'd0, 5'd7};
    #1;
    checkVal("post_rst_a0_r7", 64'(aRdData0[31:0]), 64'h55);
    checkVal("post_rst_a1_r7", 64'(aRdData1[31:0]), 64'h55);
    checkVal("post_rst_busy", 64'(aBusy0), 64'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
